mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between an instruction port and a data port.
// Data requests win unless DSTREAK_MAX consecutive data grants have starved a pending fetch.
module mem_arbiter #(
    parameter int DSTREAK_MAX = 4,
    parameter int WAIT_LIMIT  = 255
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        ihit,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dhit,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        mem_err
);

    localparam int SW = ($clog2(DSTREAK_MAX + 1) < 3) ? 3 : $clog2(DSTREAK_MAX + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(DSTREAK_MAX);
    localparam logic [7:0]    WAIT_MAX   = 8'(WAIT_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        DGRANT,
        IGRANT
    } state_t;

    typedef enum logic [1:0] {
        RAM_FREE   = 2'b00,
        RAM_BUSY   = 2'b01,
        RAM_ACCESS = 2'b10,
        RAM_ERROR  = 2'b11
    } ramstate_t;

    state_t    state, next_state;
    ramstate_t ram_st;
    logic [SW-1:0] dstreak;
    logic [7:0]    wait_cnt;
    logic          armed;
    logic          abort;
    logic          dreq;

    assign ram_st = ramstate_t'(ramstate);
    assign dreq   = dREN | dWEN;

    always_comb begin
        next_state = state;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        dhit       = 1'b0;
        ihit       = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                // armed delays the first grant after reset by one edge
                if (armed) begin
                    if (dreq && !(iREN && dstreak == STREAK_MAX))
                        next_state = DGRANT;
                    else if (iREN)
                        next_state = IGRANT;
                end
            end
            DGRANT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramREN   = dREN;
                ramWEN   = dWEN & ~dREN;
                if (!dreq) begin
                    next_state = IDLE;
                end else if (wait_cnt == WAIT_MAX || ram_st == RAM_ERROR) begin
                    abort      = 1'b1;
                    next_state = IDLE;
                end else if (ram_st == RAM_ACCESS) begin
                    dhit       = 1'b1;
                    next_state = IDLE;
                end
            end
            IGRANT: begin
                ramaddr = iaddr;
                ramREN  = 1'b1;
                if (!iREN) begin
                    next_state = IDLE;
                end else if (wait_cnt == WAIT_MAX || ram_st == RAM_ERROR) begin
                    abort      = 1'b1;
                    next_state = IDLE;
                end else if (ram_st == RAM_ACCESS) begin
                    ihit       = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign dload = dhit ? ramload : '0;
    assign iload = ihit ? ramload : '0;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= IDLE;
            armed   <= 1'b0;
            mem_err <= 1'b0;
        end else begin
            state   <= next_state;
            armed   <= 1'b1;
            mem_err <= abort;
        end
    end

    // Held at zero while idle, so the first grant cycle always sees zero.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            wait_cnt <= '0;
        else if (state == IDLE)
            wait_cnt <= '0;
        else if (next_state == state)
            wait_cnt <= wait_cnt + 8'd1;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            dstreak <= '0;
        end else if (ihit) begin
            dstreak <= '0;
        end else if (dhit) begin
            if (!iREN)
                dstreak <= '0;
            else if (dstreak != STREAK_MAX)
                dstreak <= dstreak + 1'b1;
        end
    end

endmodule
